snapshot_capture: RTL and testbench

Parametrised multi-channel sample-capture buffer with pre-/post-trigger windowing, optional decimation and channel-muxed readout, all on the AXI-side clock. Sits between the ADC/beamformer sample buses and the register file. It replaces the free-running fill-and-stop capture with armed, triggered snapshots whose read addresses are re-based to the snapshot start.

---
 rtl/snapshot_capture.sv | 229 ++++++++++++++++++++++
 tb/tb_snapshot_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_capture.sv
// Armed, triggered multi-lane snapshot buffer with pre/post-trigger windowing and 2-cycle lane-muxed readout.
// Build option: define SNAPSHOT_DECIM_EN to enable the keep-1-of-(decim+1) sample decimator.
module snapshot_capture #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 14,
  parameter int AWIDTH   = 10
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_valid,
  input  logic                      trig_in,
  input  logic                      arm,
  input  logic                      mode,
  input  logic [AWIDTH-1:0]         pretrig,
  input  logic [7:0]                decim,
  output logic                      busy,
  output logic                      done,
  output logic [AWIDTH-1:0]         trig_addr,
  input  logic                      rd_en,
  input  logic [7:0]                rd_ch,
  input  logic [AWIDTH-1:0]         rd_addr,
  output logic                      rd_valid,
  output logic [31:0]               rd_data,
  output logic [2:0]                dbg_state
);

  localparam int DEPTH = 1 << AWIDTH;

  // Handshakes: din_valid has no ready (a valid sample is either stored or skipped);
  // rd_en has no ready either and always yields rd_valid exactly two cycles later.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   wp_q, wp_d;
  logic [AWIDTH-1:0]   fill_q, fill_d;
  logic                trig_q, trig_d;
  logic                mode_q, mode_d;
  logic [AWIDTH-1:0]   pretrig_q, pretrig_d;
  logic [AWIDTH-1:0]   trig_addr_q, trig_addr_d;

  logic                capturing;
  logic                dec_zero;
  logic                accept;
  logic                wait_phase;
  logic                trig_hit;
  logic [AWIDTH-1:0]   post_len;
  logic [AWIDTH-1:0]   fill_inc;

`ifdef SNAPSHOT_DECIM_EN
  logic [7:0]          decim_q, decim_d;
  logic [7:0]          dcnt_q, dcnt_d;
  assign dec_zero = (dcnt_q == 8'd0);
`else
  logic                unused_decim;
  assign unused_decim = ^decim;
  assign dec_zero     = 1'b1;
`endif

  assign capturing  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign accept     = din_valid && capturing && dec_zero && !arm;
  // A zero-length pre-trigger window makes PRE behave exactly like WAIT.
  assign wait_phase = (state_q == S_WAIT) || ((state_q == S_PRE) && (pretrig_q == '0));
  assign trig_hit   = trig_q || (wait_phase && trig_in) || !mode_q;
  // (DEPTH-1) - pretrig, i.e. samples still owed after the trigger sample.
  assign post_len   = {AWIDTH{1'b1}} - pretrig_q;
  assign fill_inc   = fill_q + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      fill_q      <= '0;
      trig_q      <= 1'b0;
      mode_q      <= 1'b0;
      pretrig_q   <= '0;
      trig_addr_q <= '0;
`ifdef SNAPSHOT_DECIM_EN
      decim_q     <= 8'd0;
      dcnt_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      trig_q      <= trig_d;
      mode_q      <= mode_d;
      pretrig_q   <= pretrig_d;
      trig_addr_q <= trig_addr_d;
`ifdef SNAPSHOT_DECIM_EN
      decim_q     <= decim_d;
      dcnt_q      <= dcnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    trig_d      = trig_q;
    mode_d      = mode_q;
    pretrig_d   = pretrig_q;
    trig_addr_d = trig_addr_q;
`ifdef SNAPSHOT_DECIM_EN
    decim_d     = decim_q;
    dcnt_d      = dcnt_q;
`endif
    if (arm) begin
      state_d   = S_PRE;
      wp_d      = '0;
      fill_d    = '0;
      trig_d    = 1'b0;
      mode_d    = mode;
      // The port width already caps pretrig at DEPTH-1.
      pretrig_d = mode ? pretrig : '0;
`ifdef SNAPSHOT_DECIM_EN
      decim_d   = decim;
      dcnt_d    = 8'd0;
`endif
    end else begin
      if (accept) begin
        wp_d = wp_q + 1'b1;
      end
`ifdef SNAPSHOT_DECIM_EN
      if (capturing && din_valid) begin
        dcnt_d = dec_zero ? decim_q : (dcnt_q - 8'd1);
      end
`endif
      case (state_q)
        S_PRE, S_WAIT: begin
          if (wait_phase) begin
            if (accept && trig_hit) begin
              trig_addr_d = wp_q;
              trig_d      = 1'b0;
              fill_d      = '0;
              state_d     = (post_len == '0) ? S_DONE : S_POST;
            end else begin
              state_d = S_WAIT;
              if (trig_in) begin
                trig_d = 1'b1;
              end
            end
          end else if (accept) begin
            fill_d = fill_inc;
            if (fill_inc == pretrig_q) begin
              state_d = S_WAIT;
            end
          end
        end
        S_POST: begin
          if (accept) begin
            fill_d = fill_inc;
            if (fill_inc == post_len) begin
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = capturing;
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  assign trig_addr = trig_addr_q;

  logic [CHANNELS*WIDTH-1:0] mem_q [DEPTH];
  logic [CHANNELS*WIDTH-1:0] row_q;
  logic [AWIDTH-1:0]         rd_phys;
  logic                      rd_v1_q;
  logic [7:0]                rd_ch_q;
  logic                      rd_valid_q;
  logic [31:0]               rd_data_q, rd_data_d;
  logic [WIDTH-1:0]          lane_sel;
  logic                      lane_ok;

  assign rd_phys = trig_addr_q - pretrig_q + rd_addr;

  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_q[wp_q] <= din;
    end
    row_q <= mem_q[rd_phys];
  end

  always_comb begin
    lane_sel = '0;
    lane_ok  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch_q == 8'(i)) begin
        lane_sel = row_q[i*WIDTH +: WIDTH];
        lane_ok  = 1'b1;
      end
    end
    rd_data_d = lane_ok ? 32'($signed(lane_sel)) : 32'd0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_v1_q    <= 1'b0;
      rd_ch_q    <= 8'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
    end else begin
      rd_v1_q    <= rd_en;
      rd_ch_q    <= rd_ch;
      rd_valid_q <= rd_v1_q;
      if (rd_v1_q) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_snapshot_capture.sv
// Directed bench for snapshot_capture: immediate, triggered, early-trigger, decimation, re-arm and reset cases.
module tb_snapshot_capture;
  localparam int CH = 2;
  localparam int W  = 14;
  localparam int AW = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [CH*W-1:0] din;
  logic            din_valid, trig_in, arm, mode;
  logic [AW-1:0]   pretrig;
  logic [7:0]      decim;
  logic            busy, done;
  logic [AW-1:0]   trig_addr;
  logic            rd_en;
  logic [7:0]      rd_ch;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid;
  logic [31:0]     rd_data;
  logic [2:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  snapshot_capture #(.CHANNELS(CH), .WIDTH(W), .AWIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .din(din), .din_valid(din_valid),
    .trig_in(trig_in), .arm(arm), .mode(mode), .pretrig(pretrig), .decim(decim),
    .busy(busy), .done(done), .trig_addr(trig_addr),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lane0 = v, lane1 = v with bit 13/12 set (negative, exercises sign extension)
  function automatic logic [CH*W-1:0] ramp(input int v);
    logic [W-1:0] l0;
    l0 = W'(v);
    ramp = {l0 | 14'h3000, l0};
  endfunction

  task automatic arm_capture(input logic m, input logic [AW-1:0] p, input logic [7:0] d, input logic t);
    arm = 1'b1; mode = m; pretrig = p; decim = d; trig_in = t; din_valid = 1'b0;
    tick();
    arm = 1'b0; trig_in = 1'b0;
  endtask

  task automatic feed(input int v, input logic t);
    din = ramp(v); din_valid = 1'b1; trig_in = t;
    tick();
  endtask

  // back-to-back reads; expected values come from exp_q in order
  task automatic read_seq(input logic [7:0] ch, input logic [AW-1:0] a0, input int n, input string tag);
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        rd_en = 1'b1; rd_ch = ch; rd_addr = a0 + AW'(c);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (c == 0) begin
        chk({tag, "_lat"}, {31'd0, rd_valid}, 32'd0);
      end else begin
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL %s scoreboard empty observed=%0h expected=none", tag, rd_data);
        end else begin
          chk(tag, rd_data, exp_q.pop_front());
        end
      end
    end
    tick();
    chk({tag, "_idle"}, {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    int v;
    int step;
    aresetn = 1'b0; din = '0; din_valid = 1'b0; trig_in = 1'b0; arm = 1'b0;
    mode = 1'b0; pretrig = '0; decim = 8'd0; rd_en = 1'b0; rd_ch = 8'd0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_trig_addr", {28'd0, trig_addr}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    aresetn = 1'b1;
    tick();

    // immediate capture (pretrig input ignored)
    arm_capture(1'b0, 4'd7, 8'd0, 1'b0);
    chk("imm_busy", {31'd0, busy}, 32'd1);
    chk("imm_state_pre", {29'd0, dbg_state}, {29'd0, ST_PRE});
    for (int k = 0; k < 16; k++) begin
      chk("imm_done_early", {31'd0, done}, 32'd0);
      feed(k, 1'b0);
    end
    din_valid = 1'b0;
    chk("imm_done", {31'd0, done}, 32'd1);
    chk("imm_busy_end", {31'd0, busy}, 32'd0);
    chk("imm_trig_addr", {28'd0, trig_addr}, 32'd0);
    chk("imm_state_done", {29'd0, dbg_state}, {29'd0, ST_DONE});
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(k));
    read_seq(8'd0, 4'd0, 16, "imm_rd");
    exp_q.push_back(32'hFFFFF002);
    read_seq(8'd1, 4'd2, 1, "imm_sext");

    // triggered capture, trigger on sample 110, pretrig 4
    arm_capture(1'b1, 4'd4, 8'd0, 1'b0);
    for (int k = 100; k <= 121; k++) begin
      if (k == 104) chk("trg_state_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
      if (k == 111) chk("trg_state_post", {29'd0, dbg_state}, {29'd0, ST_POST});
      chk("trg_done_early", {31'd0, done}, 32'd0);
      feed(k, k == 110);
    end
    din_valid = 1'b0; trig_in = 1'b0;
    chk("trg_done", {31'd0, done}, 32'd1);
    chk("trg_trig_addr", {28'd0, trig_addr}, 32'd10);
    exp_q.push_back(32'd110);
    read_seq(8'd0, 4'd4, 1, "trg_rd4");
    exp_q.push_back(32'd106);
    read_seq(8'd0, 4'd0, 1, "trg_rd0");
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(106 + k));
    read_seq(8'd0, 4'd0, 16, "trg_rd_all");

    // trigger held through PRE is ignored until WAIT
    arm_capture(1'b1, 4'd4, 8'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk("early_done_early", {31'd0, done}, 32'd0);
      feed(k, 1'b1);
    end
    din_valid = 1'b0; trig_in = 1'b0;
    chk("early_done", {31'd0, done}, 32'd1);
    chk("early_trig_addr", {28'd0, trig_addr}, 32'd4);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(k));
    read_seq(8'd0, 4'd0, 16, "early_rd");

    // decimation with din_valid toggling
    arm_capture(1'b0, 4'd0, 8'd2, 1'b0);
    v = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) break;
      din = ramp(v);
      din_valid = (cyc % 2 == 0);
      tick();
      if (cyc % 2 == 0) v++;
    end
    din_valid = 1'b0;
    chk("dec_done", {31'd0, done}, 32'd1);
`ifdef SNAPSHOT_DECIM_EN
    step = 3;
`else
    step = 1;
`endif
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(k * step));
    read_seq(8'd0, 4'd0, 16, "dec_rd");

    // re-arm mid-POST, then re-arm together with trig_in
    arm_capture(1'b1, 4'd4, 8'd0, 1'b0);
    for (int k = 0; k <= 8; k++) feed(k, k == 6);
    din_valid = 1'b0; trig_in = 1'b0;
    chk("rearm_in_post", {29'd0, dbg_state}, {29'd0, ST_POST});
    arm_capture(1'b1, 4'd0, 8'd0, 1'b0);
    chk("rearm_busy", {31'd0, busy}, 32'd1);
    chk("rearm_done", {31'd0, done}, 32'd0);
    chk("rearm_state", {29'd0, dbg_state}, {29'd0, ST_PRE});
    arm_capture(1'b1, 4'd0, 8'd0, 1'b1);
    chk("armtrig_busy", {31'd0, busy}, 32'd1);
    chk("armtrig_done", {31'd0, done}, 32'd0);
    for (int k = 200; k <= 204; k++) begin
      feed(k, 1'b0);
      chk("armtrig_dropped", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    end
    for (int k = 205; k <= 220; k++) begin
      chk("fresh_done_early", {31'd0, done}, 32'd0);
      feed(k, k == 205);
    end
    din_valid = 1'b0; trig_in = 1'b0;
    chk("fresh_done", {31'd0, done}, 32'd1);
    chk("fresh_trig_addr", {28'd0, trig_addr}, 32'd5);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(205 + k));
    read_seq(8'd0, 4'd0, 16, "fresh_rd");

    // asynchronous reset mid-capture
    arm_capture(1'b1, 4'd0, 8'd0, 1'b0);
    rd_en = 1'b1; rd_ch = 8'd1; rd_addr = 4'd0;
    for (int k = 300; k <= 303; k++) feed(k, 1'b0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_trig_addr", {28'd0, trig_addr}, 32'd0);
    chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    chk("arst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rd_en = 1'b0; din_valid = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    for (int k = 400; k <= 403; k++) feed(k, 1'b1);
    din_valid = 1'b0; trig_in = 1'b0;
    chk("norearm_busy", {31'd0, busy}, 32'd0);
    chk("norearm_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    exp_q.push_back(32'h00000000);
    read_seq(8'd5, 4'd3, 1, "bad_lane");
    arm_capture(1'b0, 4'd0, 8'd0, 1'b0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 16; k++) feed(k + 500, 1'b0);
    din_valid = 1'b0;
    chk("restart_done", {31'd0, done}, 32'd1);
    exp_q.push_back(32'd515);
    read_seq(8'd0, 4'd15, 1, "restart_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
